wdata_router_1to2: RTL and testbench
====================================

// Module: wdata_router_1to2
// PURPOSE
//  Master-side write path of the 1-master/2-slave interconnect, complementing the slave-side R-channel mux.
//  Snoops AW handshakes, queues each burst's destination in AW order, steers W beats to that slave,
//  and returns B responses from both slaves through a grant-locked round-robin mux.
// PARAMETERS
//  DEPTH    4   destination FIFO entries; power of 2, >=2
//  SEL_BIT  28  awaddr bit selecting slave: 0 -> s1, 1 -> s2
//  ID_W     4   BID width
//  DATA_W   32  WDATA width; WSTRB is DATA_W/8
// PORTS
//  aclk              in   1         clock, rising edge
//  areset            in   1         async reset, active-high
//  awaddr_m          in   32        master AW address (snooped)
//  awvalid_m         in   1         master AW valid (snooped)
//  awready_m         in   1         AW ready as seen by master (snooped)
//  aw_full           out  1         FIFO full; AW logic must hold awready_m low while 1
//  wdata_m/wstrb_m   in   DATA_W/DATA_W/8  master W payload
//  wlast_m           in   1         last beat of burst
//  wvalid_m          in   1         master W valid
//  wready_m          out  1         W ready to master
//  wdata_s1/_s2      out  DATA_W    W data to slave 1/2 (wstrb_sX, wlast_sX likewise)
//  wvalid_s1/_s2     out  1         W valid to slave 1/2
//  wready_s1/_s2     in   1         W ready from slave 1/2
//  bid_s1/_s2        in   ID_W      B id from slave 1/2 (bresp_sX 2b, bvalid_sX 1b likewise)
//  bready_s1/_s2     out  1         B ready to slave 1/2
//  bid_m/bresp_m     out  ID_W/2    muxed B id/resp
//  bvalid_m          out  1         muxed B valid
//  bready_m          in   1         master B ready
//  ovf_err           out  1         sticky: AW handshake seen while FIFO full
// BEHAVIOUR
//  Reset: FIFO empty, count 0, aw_full 0, ovf_err 0, B state IDLE, grant s1, last-served s2 (s1 first).
//   All valid/ready outputs 0 during and after reset until conditions below hold.
//  Push: awvalid_m & awready_m -> push awaddr_m[SEL_BIT]; entry visible next cycle (no W bypass).
//  Push while full -> dropped, ovf_err set; cleared only by areset.
//  aw_full = (count == DEPTH); count width log2(DEPTH)+1; pointers wrap modulo DEPTH.
//  W steering: FIFO empty -> wready_m 0, wvalid_s1/_s2 0. Non-empty: head h selects slave:
//   wvalid_sh = wvalid_m, wready_m = wready_sh; other slave wvalid 0. Payload driven to both slaves.
//  Pop: wvalid_m & wready_m & wlast_m -> pop head; next burst's beats steered from next cycle.
//  Push and pop in same cycle: count unchanged; legal even when full (pop frees, push lands).
//  Non-last beats never pop; W is purely combinational through a stable head (zero latency).
//  B mux FSM, states IDLE/BUSY:
//   IDLE: bvalid_m 0, bready_s1/_s2 0. If any bvalid_sX: grant = requester; both -> the slave
//    not last served. Go BUSY next cycle.
//   BUSY: bid_m/bresp_m/bvalid_m from granted slave, bready_granted = bready_m, other bready 0.
//    On bvalid_m & bready_m: last-served = grant, go IDLE. Grant held while bready_m low.
//  B latency: bvalid_sX to bvalid_m = 1 cycle; min 2 cycles per B response.
//  bid_m/bresp_m driven 0 in IDLE.
//  Reset mid-burst: FIFO flushed, any in-flight W/B transfer abandoned; outputs to reset values at once.
// TESTING
//  T1 AW addr 0x0000_0100 handshake, then 4-beat burst wlast on beat 4 -> beats on s1 only, pop after beat 4, count 1->0.
//  T2 AW 0x1000_0000 then AW 0x0000_0000 back-to-back, W bursts 2+3 beats -> first 2 beats s2, next 3 beats s1, order kept.
//  T3 4 AWs with no W (DEPTH=4) -> aw_full 1; 5th forced handshake -> ovf_err 1, count stays 4.
//  T4 full FIFO, last-beat pop and AW push same cycle -> count stays 4, new entry at tail.
//  T5 bvalid_s1 & bvalid_s2 same cycle, bready_m stalled 3 cycles -> s1 granted and held 3 cycles, then s2; next tie -> s1.
//  T6 areset pulse mid-burst beat 2 of 4 -> wready_m 0, count 0, B IDLE; new AW+burst afterwards routes correctly.

Source files
------------

// File: rtl/wdata_router_1to2_if.sv
`default_nettype none
// ============================================================================
// Module   : wdata_router_1to2_if
// Brief    : Bundle of snooped AW, W (master + two slaves) and B (master + two
//            slaves) signals for the 1-master/2-slave write router.
// Revision : 1.0 - initial release
// ============================================================================
interface wdata_router_1to2_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic [31:0]       awaddr_m;
  logic              awvalid_m;
  logic              awready_m;
  logic              aw_full;

  logic [DATA_W-1:0] wdata_m;
  logic [STRB_W-1:0] wstrb_m;
  logic              wlast_m;
  logic              wvalid_m;
  logic              wready_m;

  logic [DATA_W-1:0] wdata_s1;
  logic [STRB_W-1:0] wstrb_s1;
  logic              wlast_s1;
  logic              wvalid_s1;
  logic              wready_s1;
  logic [DATA_W-1:0] wdata_s2;
  logic [STRB_W-1:0] wstrb_s2;
  logic              wlast_s2;
  logic              wvalid_s2;
  logic              wready_s2;

  logic [ID_W-1:0]   bid_s1;
  logic [1:0]        bresp_s1;
  logic              bvalid_s1;
  logic              bready_s1;
  logic [ID_W-1:0]   bid_s2;
  logic [1:0]        bresp_s2;
  logic              bvalid_s2;
  logic              bready_s2;

  logic [ID_W-1:0]   bid_m;
  logic [1:0]        bresp_m;
  logic              bvalid_m;
  logic              bready_m;

  logic              ovf_err;

  // Router's view of the bundle
  modport slave (
    input  awaddr_m, awvalid_m, awready_m,
    output aw_full,
    input  wdata_m, wstrb_m, wlast_m, wvalid_m,
    output wready_m,
    output wdata_s1, wstrb_s1, wlast_s1, wvalid_s1,
    input  wready_s1,
    output wdata_s2, wstrb_s2, wlast_s2, wvalid_s2,
    input  wready_s2,
    input  bid_s1, bresp_s1, bvalid_s1,
    output bready_s1,
    input  bid_s2, bresp_s2, bvalid_s2,
    output bready_s2,
    output bid_m, bresp_m, bvalid_m,
    input  bready_m,
    output ovf_err
  );

  // Environment's view: drives master-side requests and slave-side responses
  modport master (
    output awaddr_m, awvalid_m, awready_m,
    input  aw_full,
    output wdata_m, wstrb_m, wlast_m, wvalid_m,
    input  wready_m,
    input  wdata_s1, wstrb_s1, wlast_s1, wvalid_s1,
    output wready_s1,
    input  wdata_s2, wstrb_s2, wlast_s2, wvalid_s2,
    output wready_s2,
    output bid_s1, bresp_s1, bvalid_s1,
    input  bready_s1,
    output bid_s2, bresp_s2, bvalid_s2,
    input  bready_s2,
    input  bid_m, bresp_m, bvalid_m,
    output bready_m,
    input  ovf_err
  );
endinterface
`default_nettype wire

// File: rtl/wdata_router_1to2.sv
`default_nettype none
// ============================================================================
// Module   : wdata_router_1to2
// Brief    : Queues AW destinations in order, steers W bursts to slave 1/2 and
//            merges B responses through a grant-locked round-robin mux.
// Revision : 1.0 - initial release
// ============================================================================
module wdata_router_1to2 #(
  parameter int DEPTH   = 4,
  parameter int SEL_BIT = 28,
  parameter int ID_W    = 4,
  parameter int DATA_W  = 32
) (
  input  logic               aclk,
  input  logic               areset,
  wdata_router_1to2_if.slave bus
);
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam int               STRB_W   = DATA_W / 8;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [0:0]       B_IDLE   = 1'b0;
  localparam logic [0:0]       B_BUSY   = 1'b1;

  // Destination FIFO: one bit per entry, 0 -> s1, 1 -> s2
  logic [DEPTH-1:0] dest_q, dest_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic fifo_empty, fifo_full, head;
  logic aw_hs, push, pop;
  logic to_s1, to_s2, w_ready;

  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    head       = dest_q[rd_ptr_q];
    to_s1      = !fifo_empty && !head;
    to_s2      = !fifo_empty && head;
    w_ready    = (to_s1 && bus.wready_s1) || (to_s2 && bus.wready_s2);
    aw_hs      = bus.awvalid_m && bus.awready_m;
    pop        = bus.wvalid_m && w_ready && bus.wlast_m;
    // A pop in the same cycle frees the slot a push into a full FIFO needs
    push       = aw_hs && (!fifo_full || pop);

    dest_d = dest_q;
    if (push) begin
      dest_d[wr_ptr_q] = bus.awaddr_m[SEL_BIT];
    end
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q || (aw_hs && fifo_full && !pop);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      dest_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      dest_q   <= dest_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign w_data        = bus.wdata_m;
  assign w_strb        = bus.wstrb_m;
  assign bus.wdata_s1  = w_data;
  assign bus.wstrb_s1  = w_strb;
  assign bus.wlast_s1  = bus.wlast_m;
  assign bus.wdata_s2  = w_data;
  assign bus.wstrb_s2  = w_strb;
  assign bus.wlast_s2  = bus.wlast_m;
  assign bus.wvalid_s1 = to_s1 && bus.wvalid_m;
  assign bus.wvalid_s2 = to_s2 && bus.wvalid_m;
  assign bus.wready_m  = w_ready;
  assign bus.aw_full   = fifo_full;
  assign bus.ovf_err   = ovf_q;

  // B response mux: grant 0 -> s1, 1 -> s2; last_q starts at s2 so s1 wins the first tie
  logic [0:0]      b_state_q, b_state_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;
  logic            b_valid_sel;
  logic [ID_W-1:0] b_id_sel;
  logic [1:0]      b_resp_sel;
  logic            b_ready_s1, b_ready_s2;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      b_state_q <= B_IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      b_state_q <= b_state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    b_state_d = b_state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    case (b_state_q)
      B_IDLE: begin
        if (bus.bvalid_s1 || bus.bvalid_s2) begin
          b_state_d = B_BUSY;
          grant_d   = (bus.bvalid_s1 && bus.bvalid_s2) ? !last_q : bus.bvalid_s2;
        end
      end
      B_BUSY: begin
        if (b_valid_sel && bus.bready_m) begin
          b_state_d = B_IDLE;
          last_d    = grant_q;
        end
      end
      default: b_state_d = B_IDLE;
    endcase
  end

  always_comb begin
    b_valid_sel = 1'b0;
    b_id_sel    = '0;
    b_resp_sel  = 2'b00;
    b_ready_s1  = 1'b0;
    b_ready_s2  = 1'b0;
    if (b_state_q == B_BUSY) begin
      if (grant_q) begin
        b_valid_sel = bus.bvalid_s2;
        b_id_sel    = bus.bid_s2;
        b_resp_sel  = bus.bresp_s2;
        b_ready_s2  = bus.bready_m;
      end else begin
        b_valid_sel = bus.bvalid_s1;
        b_id_sel    = bus.bid_s1;
        b_resp_sel  = bus.bresp_s1;
        b_ready_s1  = bus.bready_m;
      end
    end
  end

  assign bus.bvalid_m  = b_valid_sel;
  assign bus.bid_m     = b_id_sel;
  assign bus.bresp_m   = b_resp_sel;
  assign bus.bready_s1 = b_ready_s1;
  assign bus.bready_s2 = b_ready_s2;

endmodule
`default_nettype wire

// File: tb/tb_wdata_router_1to2.sv
`default_nettype none
// ============================================================================
// Module   : tb_wdata_router_1to2
// Brief    : Self-checking bench: destination-queue model for W routing and a
//            transaction-order model for the round-robin B mux.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wdata_router_1to2;
  localparam int DEPTH   = 4;
  localparam int SEL_BIT = 28;
  localparam int ID_W    = 4;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = DATA_W / 8;

  typedef struct packed {
    logic            src;
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_t;

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  wdata_router_1to2_if #(.DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  wdata_router_1to2 #(
    .DEPTH(DEPTH), .SEL_BIT(SEL_BIT), .ID_W(ID_W), .DATA_W(DATA_W)
  ) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit dst_q[$];   // expected destination of each queued burst, oldest first
  bit m_ovf;

  task automatic drive_idle();
    bus.awaddr_m = '0; bus.awvalid_m = 1'b0; bus.awready_m = 1'b0;
    bus.wdata_m = '0; bus.wstrb_m = '0; bus.wlast_m = 1'b0; bus.wvalid_m = 1'b0;
    bus.wready_s1 = 1'b0; bus.wready_s2 = 1'b0;
    bus.bid_s1 = '0; bus.bresp_s1 = 2'b00; bus.bvalid_s1 = 1'b0;
    bus.bid_s2 = '0; bus.bresp_s2 = 2'b00; bus.bvalid_s2 = 1'b0;
    bus.bready_m = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    drive_idle();
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    dst_q.delete();
    m_ovf = 1'b0;
  endtask

  // One clock of AW/W traffic: outputs compared against the queue model, then the model advances
  task automatic run_cycle(input logic aw_v, input logic [31:0] addr, input logic w_v,
                           input logic last, input logic wr1, input logic wr2, output logic acc);
    logic              exp_v1, exp_v2, exp_rdy, h, full_m, pop_m, nonempty;
    logic [DATA_W-1:0] d;
    logic [STRB_W-1:0] s;
    @(negedge aclk);
    d = DATA_W'($urandom);
    s = STRB_W'($urandom);
    bus.awvalid_m = aw_v; bus.awready_m = aw_v; bus.awaddr_m = addr;
    bus.wvalid_m = w_v; bus.wlast_m = last; bus.wdata_m = d; bus.wstrb_m = s;
    bus.wready_s1 = wr1; bus.wready_s2 = wr2;
    #1;
    nonempty = (dst_q.size() != 0);
    full_m   = (dst_q.size() == DEPTH);
    h        = nonempty ? dst_q[0] : 1'b0;
    exp_v1   = nonempty && w_v && !h;
    exp_v2   = nonempty && w_v && h;
    exp_rdy  = nonempty && (h ? wr2 : wr1);
    checks++;
    if (bus.wvalid_s1 !== exp_v1) begin
      errors++; $display("FAIL wvalid_s1 @%0t: got %b want %b", $time, bus.wvalid_s1, exp_v1);
    end
    checks++;
    if (bus.wvalid_s2 !== exp_v2) begin
      errors++; $display("FAIL wvalid_s2 @%0t: got %b want %b", $time, bus.wvalid_s2, exp_v2);
    end
    checks++;
    if (bus.wready_m !== exp_rdy) begin
      errors++; $display("FAIL wready_m @%0t: got %b want %b", $time, bus.wready_m, exp_rdy);
    end
    checks++;
    if (bus.aw_full !== full_m) begin
      errors++; $display("FAIL aw_full @%0t: got %b want %b", $time, bus.aw_full, full_m);
    end
    checks++;
    if (bus.ovf_err !== m_ovf) begin
      errors++; $display("FAIL ovf_err @%0t: got %b want %b", $time, bus.ovf_err, m_ovf);
    end
    checks++;
    if ({bus.wdata_s1, bus.wstrb_s1, bus.wlast_s1} !== {d, s, last} ||
        {bus.wdata_s2, bus.wstrb_s2, bus.wlast_s2} !== {d, s, last}) begin
      errors++;
      $display("FAIL w_payload @%0t: got s1 %h/%h/%b s2 %h/%h/%b want %h/%h/%b", $time,
               bus.wdata_s1, bus.wstrb_s1, bus.wlast_s1, bus.wdata_s2, bus.wstrb_s2,
               bus.wlast_s2, d, s, last);
    end
    @(posedge aclk);
    pop_m = w_v && exp_rdy && last;
    if (aw_v && full_m && !pop_m) m_ovf = 1'b1;
    if (pop_m) void'(dst_q.pop_front());
    if (aw_v && (!full_m || pop_m)) dst_q.push_back(addr[SEL_BIT]);
    acc = w_v && exp_rdy;
  endtask

  task automatic send_burst(input int len);
    int   beat  = 0;
    int   guard = 0;
    logic acc;
    while (beat < len && guard < 100) begin
      run_cycle(1'b0, 32'h0, 1'b1, (beat == len - 1), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, acc);
      if (acc) beat++;
      guard++;
    end
    checks++;
    if (beat != len) begin
      errors++; $display("FAIL burst_timeout: got %0d beats want %0d", beat, len);
    end
  endtask

  task automatic test_reset();
    logic acc;
    drive_idle();
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    bus.wvalid_m = 1'b1; bus.wready_s1 = 1'b1; bus.wready_s2 = 1'b1;
    bus.bvalid_s1 = 1'b1; bus.bvalid_s2 = 1'b1; bus.bready_m = 1'b1;
    @(negedge aclk); #1;
    checks++;
    if ({bus.wready_m, bus.wvalid_s1, bus.wvalid_s2} !== 3'b000) begin
      errors++; $display("FAIL reset_w: got %b want 000", {bus.wready_m, bus.wvalid_s1, bus.wvalid_s2});
    end
    checks++;
    if ({bus.bvalid_m, bus.bready_s1, bus.bready_s2} !== 3'b000) begin
      errors++; $display("FAIL reset_b: got %b want 000", {bus.bvalid_m, bus.bready_s1, bus.bready_s2});
    end
    checks++;
    if ({bus.aw_full, bus.ovf_err, bus.bid_m, bus.bresp_m} !== '0) begin
      errors++; $display("FAIL reset_flags: got %b/%b/%h/%h want 0", bus.aw_full, bus.ovf_err, bus.bid_m, bus.bresp_m);
    end
    drive_idle();
    @(negedge aclk);
    areset = 1'b0;
    dst_q.delete();
    m_ovf = 1'b0;
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
  endtask

  task automatic test_single_burst();
    logic acc;
    // W presented in the AW cycle must not bypass the empty queue
    run_cycle(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 1'b1, acc);
    send_burst(4);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
  endtask

  task automatic test_back_to_back();
    logic acc;
    run_cycle(1'b1, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    run_cycle(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    send_burst(2);
    send_burst(3);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
  endtask

  task automatic test_random_traffic();
    int   beat = 0;
    int   len  = $urandom_range(1, 4);
    int   guard = 0;
    logic acc, aw_v, w_v;
    for (int c = 0; c < 300; c++) begin
      aw_v = ($urandom_range(0, 2) == 0) && (dst_q.size() < DEPTH);
      w_v  = ($urandom_range(0, 3) != 0);
      run_cycle(aw_v, $urandom, w_v, (beat == len - 1), $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, acc);
      if (acc) begin
        if (beat == len - 1) begin
          beat = 0;
          len  = $urandom_range(1, 4);
        end else begin
          beat++;
        end
      end
    end
    if (dst_q.size() != 0) send_burst(len - beat);
    while (dst_q.size() != 0 && guard < 10) begin
      send_burst($urandom_range(1, 3));
      guard++;
    end
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
  endtask

  task automatic test_overflow();
    logic acc;
    do_reset();
    for (int i = 0; i < DEPTH; i++) run_cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    @(negedge aclk);
    drive_idle();
    #1;
    checks++;
    if ({bus.aw_full, bus.ovf_err} !== 2'b10) begin
      errors++; $display("FAIL full_flag: got %b want 10", {bus.aw_full, bus.ovf_err});
    end
    run_cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    @(negedge aclk);
    drive_idle();
    #1;
    checks++;
    if ({bus.aw_full, bus.ovf_err} !== 2'b11) begin
      errors++; $display("FAIL ovf_set: got %b want 11", {bus.aw_full, bus.ovf_err});
    end
    for (int i = 0; i < DEPTH; i++) send_burst(1);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
  endtask

  task automatic test_full_push_pop();
    logic        acc;
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < DEPTH; i++) run_cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    a = $urandom;
    run_cycle(1'b1, a, 1'b1, 1'b1, 1'b1, 1'b1, acc);
    @(negedge aclk);
    drive_idle();
    #1;
    checks++;
    if ({bus.aw_full, bus.ovf_err} !== 2'b10) begin
      errors++; $display("FAIL push_pop_full: got %b want 10", {bus.aw_full, bus.ovf_err});
    end
    for (int i = 0; i < DEPTH; i++) send_burst(1);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
  endtask

  task automatic test_b_tie();
    logic [1:0] r1, r2;
    do_reset();
    r1 = 2'($urandom);
    r2 = 2'($urandom);
    @(negedge aclk);
    bus.bvalid_s1 = 1'b1; bus.bid_s1 = 4'h3; bus.bresp_s1 = r1;
    bus.bvalid_s2 = 1'b1; bus.bid_s2 = 4'hA; bus.bresp_s2 = r2;
    bus.bready_m  = 1'b0;
    #1;
    checks++;
    if ({bus.bvalid_m, bus.bready_s1, bus.bready_s2, bus.bid_m} !== '0) begin
      errors++; $display("FAIL b_idle_first: got %b%b%b id %h want 000 id 0", bus.bvalid_m, bus.bready_s1, bus.bready_s2, bus.bid_m);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk); #1;
      checks++;
      if ({bus.bvalid_m, bus.bid_m, bus.bresp_m, bus.bready_s1, bus.bready_s2} !== {1'b1, 4'h3, r1, 2'b00}) begin
        errors++; $display("FAIL b_hold_s1: got v%b id %h r%h rdy %b%b want v1 id 3 r%h rdy 00",
                           bus.bvalid_m, bus.bid_m, bus.bresp_m, bus.bready_s1, bus.bready_s2, r1);
      end
    end
    @(negedge aclk);
    bus.bready_m = 1'b1;
    #1;
    checks++;
    if ({bus.bready_s1, bus.bready_s2} !== 2'b10) begin
      errors++; $display("FAIL b_ready_s1: got %b%b want 10", bus.bready_s1, bus.bready_s2);
    end
    @(negedge aclk);
    bus.bvalid_s1 = 1'b0;
    #1;
    checks++;
    if (bus.bvalid_m !== 1'b0) begin
      errors++; $display("FAIL b_gap: got %b want 0", bus.bvalid_m);
    end
    @(negedge aclk); #1;
    checks++;
    if ({bus.bvalid_m, bus.bid_m, bus.bresp_m, bus.bready_s1, bus.bready_s2} !== {1'b1, 4'hA, r2, 2'b01}) begin
      errors++; $display("FAIL b_then_s2: got v%b id %h r%h rdy %b%b want v1 id a r%h rdy 01",
                         bus.bvalid_m, bus.bid_m, bus.bresp_m, bus.bready_s1, bus.bready_s2, r2);
    end
    @(negedge aclk);
    bus.bvalid_s2 = 1'b0;
    @(negedge aclk);
    bus.bvalid_s1 = 1'b1; bus.bid_s1 = 4'h5;
    bus.bvalid_s2 = 1'b1; bus.bid_s2 = 4'hC;
    @(negedge aclk); #1;
    checks++;
    if ({bus.bvalid_m, bus.bid_m, bus.bready_s1, bus.bready_s2} !== {1'b1, 4'h5, 2'b10}) begin
      errors++; $display("FAIL b_next_tie: got v%b id %h rdy %b%b want v1 id 5 rdy 10",
                         bus.bvalid_m, bus.bid_m, bus.bready_s1, bus.bready_s2);
    end
    @(negedge aclk);
    drive_idle();
  endtask

  task automatic test_b_random();
    b_t   q1[$], q2[$], exp_q[$];
    b_t   item, got;
    int   n1, n2, i1, i2, cyc;
    bit   turn;
    logic hs1, hs2, hsm;
    do_reset();
    n1 = $urandom_range(1, 6);
    n2 = $urandom_range(1, 6);
    for (int i = 0; i < n1; i++) q1.push_back({1'b0, ID_W'($urandom), 2'($urandom)});
    for (int i = 0; i < n2; i++) q2.push_back({1'b1, ID_W'($urandom), 2'($urandom)});
    // Both slaves stay busy, so service alternates starting with s1 until one drains
    i1 = 0; i2 = 0; turn = 1'b0;
    while (i1 < n1 || i2 < n2) begin
      if (i1 < n1 && (i2 >= n2 || !turn)) begin
        exp_q.push_back(q1[i1]); i1++; turn = 1'b1;
      end else begin
        exp_q.push_back(q2[i2]); i2++; turn = 1'b0;
      end
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge aclk);
      bus.bvalid_s1 = (q1.size() != 0);
      bus.bvalid_s2 = (q2.size() != 0);
      item = (q1.size() != 0) ? q1[0] : '0;
      bus.bid_s1 = item.id; bus.bresp_s1 = item.resp;
      item = (q2.size() != 0) ? q2[0] : '0;
      bus.bid_s2 = item.id; bus.bresp_s2 = item.resp;
      bus.bready_m = ($urandom_range(0, 2) != 0);
      #1;
      hs1 = bus.bvalid_s1 && bus.bready_s1;
      hs2 = bus.bvalid_s2 && bus.bready_s2;
      hsm = bus.bvalid_m && bus.bready_m;
      checks++;
      if ((bus.bready_s1 && bus.bready_s2) || ((bus.bready_s1 || bus.bready_s2) && !bus.bready_m)) begin
        errors++; $display("FAIL b_ready_excl: got rdy %b%b with bready_m %b", bus.bready_s1, bus.bready_s2, bus.bready_m);
      end
      if (hsm) begin
        got = {exp_q[0].src, bus.bid_m, bus.bresp_m};
        checks++;
        if (got !== exp_q[0] || (exp_q[0].src ? !hs2 : !hs1)) begin
          errors++; $display("FAIL b_order: got id %h r%h rdy %b%b want src %b id %h r%h",
                             bus.bid_m, bus.bresp_m, bus.bready_s1, bus.bready_s2,
                             exp_q[0].src, exp_q[0].id, exp_q[0].resp);
        end
      end else if (!bus.bvalid_m) begin
        checks++;
        if ({bus.bid_m, bus.bresp_m} !== '0) begin
          errors++; $display("FAIL b_idle_zero: got id %h r%h want 0", bus.bid_m, bus.bresp_m);
        end
      end
      @(posedge aclk);
      if (hs1) void'(q1.pop_front());
      if (hs2) void'(q2.pop_front());
      if (hsm) void'(exp_q.pop_front());
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b_timeout: got %0d responses pending want 0", exp_q.size());
    end
    @(negedge aclk);
    drive_idle();
  endtask

  task automatic test_reset_mid_burst();
    logic acc;
    do_reset();
    run_cycle(1'b1, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    @(negedge aclk);
    bus.awvalid_m = 1'b0; bus.awready_m = 1'b0;
    bus.bvalid_s1 = 1'b1; bus.bid_s1 = 4'h7; bus.bready_m = 1'b0;
    run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    @(negedge aclk); #1;
    checks++;
    if ({bus.wready_m, bus.wvalid_s2, bus.bvalid_m} !== 3'b111) begin
      errors++; $display("FAIL pre_reset: got %b want 111", {bus.wready_m, bus.wvalid_s2, bus.bvalid_m});
    end
    areset = 1'b1;
    bus.bready_m = 1'b1;
    #1;
    checks++;
    if ({bus.wready_m, bus.wvalid_s1, bus.wvalid_s2, bus.aw_full} !== 4'b0000) begin
      errors++; $display("FAIL reset_mid_w: got %b want 0000", {bus.wready_m, bus.wvalid_s1, bus.wvalid_s2, bus.aw_full});
    end
    checks++;
    if ({bus.bvalid_m, bus.bready_s1, bus.bready_s2} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_b: got %b want 000", {bus.bvalid_m, bus.bready_s1, bus.bready_s2});
    end
    drive_idle();
    @(negedge aclk);
    areset = 1'b0;
    dst_q.delete();
    m_ovf = 1'b0;
    run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, acc);
    run_cycle(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    send_burst(4);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_ovf = 1'b0;
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_random_traffic();
    test_overflow();
    test_full_push_pop();
    test_b_tie();
    test_b_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
